// File: rtl/lcd_display_location_poller_if.sv
// Avalon-MM read-only bus between the location poller (master) and the LCD
// location register slave.
interface lcd_display_location_poller_if;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/lcd_display_location_poller.sv
// Periodically reads the LCD display location bit over Avalon-MM, tracks the
// last value, and counts/pulses on every change; a stalled slave is abandoned.
module lcd_display_location_poller #(
    parameter int POLL_INTERVAL = 50000,
    parameter int READ_LATENCY  = 1,
    parameter int TIMEOUT       = 15
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    lcd_display_location_poller_if.master        avm,
    output logic                                 location,
    output logic                                 location_valid,
    output logic                                 change_pulse,
    output logic [15:0]                          change_count,
    output logic                                 timeout_err
);

    localparam int IW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [IW-1:0] INTERVAL_LAST = IW'(POLL_INTERVAL - 1);
    localparam logic [7:0]    TIMEOUT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0]    LAT_LAST      = 3'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LAT,
        CAP
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] interval_cnt, interval_next;
    logic [7:0]    timeout_cnt, timeout_next;
    logic [2:0]    lat_cnt, lat_next;
    logic          timeout_hit;
    logic          new_bit;
    logic          unused_readdata;

    assign new_bit         = avm.avm_readdata[0];
    assign unused_readdata = ^avm.avm_readdata[31:1];
    assign avm.avm_read    = (state == REQ);
    assign avm.avm_address = 2'b00;

    // Latency 1 means data is valid right after acceptance, so LAT is skipped.
    always_comb begin
        state_next    = state;
        interval_next = interval_cnt;
        timeout_next  = timeout_cnt;
        lat_next      = lat_cnt;
        timeout_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (interval_cnt == INTERVAL_LAST) begin
                        state_next    = REQ;
                        interval_next = '0;
                        timeout_next  = '0;
                    end else begin
                        interval_next = interval_cnt + 1'b1;
                    end
                end
            end
            REQ: begin
                if (!avm.avm_waitrequest) begin
                    timeout_next = '0;
                    lat_next     = '0;
                    state_next   = (READ_LATENCY > 1) ? LAT : CAP;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    timeout_hit   = 1'b1;
                    timeout_next  = '0;
                    interval_next = '0;
                    state_next    = IDLE;
                end else begin
                    timeout_next = timeout_cnt + 1'b1;
                end
            end
            LAT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_next = CAP;
                end else begin
                    lat_next = lat_cnt + 1'b1;
                end
            end
            CAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The change pulse lands together with the updated location value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            interval_cnt   <= '0;
            timeout_cnt    <= '0;
            lat_cnt        <= '0;
            location       <= 1'b0;
            location_valid <= 1'b0;
            change_pulse   <= 1'b0;
            change_count   <= '0;
            timeout_err    <= 1'b0;
        end else begin
            state        <= state_next;
            interval_cnt <= interval_next;
            timeout_cnt  <= timeout_next;
            lat_cnt      <= lat_next;
            change_pulse <= 1'b0;
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (state == CAP) begin
                location       <= new_bit;
                location_valid <= 1'b1;
                if (location_valid && (new_bit != location)) begin
                    change_pulse <= 1'b1;
                    change_count <= change_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_display_location_poller.sv
// Directed bench: two poller instances (latency 1 / timeout 5, latency 3 /
// timeout 15) against slave models that expose the location bit only in the exact data cycle.
module tb_lcd_display_location_poller;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic bit_a;
    logic bit_b;
    int   stall_a;
    int   stall_b;
    int   read_run_a = 0;
    int   read_run_b = 0;
    logic       pipe_a = 1'b0;
    logic [2:0] pipe_b = 3'b000;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        location_a, location_valid_a, change_pulse_a, timeout_err_a;
    logic [15:0] change_count_a;
    logic        location_b, location_valid_b, change_pulse_b, timeout_err_b;
    logic [15:0] change_count_b;

    lcd_display_location_poller_if if_a ();
    lcd_display_location_poller_if if_b ();

    lcd_display_location_poller #(
        .POLL_INTERVAL(4),
        .READ_LATENCY (1),
        .TIMEOUT      (5)
    ) dut_a (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .avm           (if_a),
        .location      (location_a),
        .location_valid(location_valid_a),
        .change_pulse  (change_pulse_a),
        .change_count  (change_count_a),
        .timeout_err   (timeout_err_a)
    );

    lcd_display_location_poller #(
        .POLL_INTERVAL(4),
        .READ_LATENCY (3),
        .TIMEOUT      (15)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .avm           (if_b),
        .location      (location_b),
        .location_valid(location_valid_b),
        .change_pulse  (change_pulse_b),
        .change_count  (change_count_b),
        .timeout_err   (timeout_err_b)
    );

    always #5 clk = ~clk;

    // Slave models: stall for the first stall_x cycles of a read, then return
    // the location bit only in the data cycle (inverted everywhere else).
    assign if_a.avm_waitrequest = if_a.avm_read && (read_run_a < stall_a);
    assign if_b.avm_waitrequest = if_b.avm_read && (read_run_b < stall_b);
    assign if_a.avm_readdata = pipe_a    ? {{31{~bit_a}}, bit_a} : {{31{bit_a}}, ~bit_a};
    assign if_b.avm_readdata = pipe_b[2] ? {{31{~bit_b}}, bit_b} : {{31{bit_b}}, ~bit_b};

    always @(posedge clk) begin
        read_run_a <= if_a.avm_read ? read_run_a + 1 : 0;
        read_run_b <= if_b.avm_read ? read_run_b + 1 : 0;
        pipe_a     <= if_a.avm_read && !if_a.avm_waitrequest;
        pipe_b     <= {pipe_b[1:0], if_b.avm_read && !if_b.avm_waitrequest};
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Runs one poll on dut_a from an IDLE negedge; returns at the negedge after
    // avm_read falls (CAP for a completed read, IDLE after a timeout).
    task automatic applyStimulus(input string tag, input logic bit_val, input int stall,
                                 input logic drop_en, input int exp_gap, input int exp_high);
        int n;
        int h;
        bit_a   = bit_val;
        stall_a = stall;
        enable  = 1'b1;
        n = 0;
        while (!if_a.avm_read && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " gap"}, n, exp_gap);
        checkOutput({tag, " addr"}, {30'd0, if_a.avm_address}, 0);
        if (drop_en) enable = 1'b0;
        h = 0;
        while (if_a.avm_read && h < 40) begin
            @(negedge clk);
            h++;
        end
        checkOutput({tag, " read_high"}, h, exp_high);
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        bit_a   = 1'b0;
        bit_b   = 1'b1;
        stall_a = 0;
        stall_b = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst read", if_a.avm_read, 0);
        checkOutput("rst location", location_a, 0);
        checkOutput("rst valid", location_valid_a, 0);
        checkOutput("rst count", change_count_a, 0);
        checkOutput("rst terr", timeout_err_a, 0);

        reset = 1'b0;
        applyStimulus("poll1", 1'b1, 0, 1'b0, 4, 1);
        @(negedge clk);
        checkOutput("poll1 location", location_a, 1);
        checkOutput("poll1 valid", location_valid_a, 1);
        checkOutput("poll1 pulse", change_pulse_a, 0);
        checkOutput("poll1 count", change_count_a, 0);

        applyStimulus("poll2", 1'b0, 0, 1'b0, 4, 1);
        @(negedge clk);
        checkOutput("poll2 location", location_a, 0);
        checkOutput("poll2 pulse", change_pulse_a, 1);
        checkOutput("poll2 count", change_count_a, 1);

        applyStimulus("poll3", 1'b1, 3, 1'b1, 4, 4);
        @(negedge clk);
        checkOutput("poll3 location", location_a, 1);
        checkOutput("poll3 pulse", change_pulse_a, 1);
        checkOutput("poll3 count", change_count_a, 2);
        checkOutput("poll3 terr", timeout_err_a, 0);

        applyStimulus("tmo", 1'b0, 1000, 1'b0, 4, 5);
        checkOutput("tmo terr", timeout_err_a, 1);
        checkOutput("tmo location", location_a, 1);
        checkOutput("tmo count", change_count_a, 2);
        checkOutput("tmo valid", location_valid_a, 1);

        // Enable low must freeze the interval counter at 2, not clear it.
        begin
            int reads_seen;
            reads_seen = 0;
            enable = 1'b1;
            repeat (2) @(negedge clk);
            enable = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (if_a.avm_read) reads_seen++;
            end
            checkOutput("hold reads", reads_seen, 0);
        end
        applyStimulus("poll4", 1'b1, 0, 1'b0, 2, 1);
        @(negedge clk);
        checkOutput("poll4 location", location_a, 1);
        checkOutput("poll4 pulse", change_pulse_a, 0);
        checkOutput("poll4 terr", timeout_err_a, 1);

        force dut_a.change_count = 16'hFFFF;
        #1;
        release dut_a.change_count;
        applyStimulus("wrap", 1'b0, 0, 1'b0, 4, 1);
        @(negedge clk);
        checkOutput("wrap location", location_a, 0);
        checkOutput("wrap pulse", change_pulse_a, 1);
        checkOutput("wrap count", change_count_a, 0);

        checkOutput("lat3 location", location_b, 1);
        checkOutput("lat3 valid", location_valid_b, 1);
        checkOutput("lat3 count", change_count_b, 0);

        // Reset dut_b while its read sits in LAT; the late data must be dropped.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        begin
            int n;
            n = 0;
            while (!if_b.avm_read && n < 40) begin
                @(negedge clk);
                n++;
            end
            checkOutput("lat3 gap", n, 4);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst read", if_b.avm_read, 0);
        checkOutput("midrst location", location_b, 0);
        checkOutput("midrst valid", location_valid_b, 0);
        checkOutput("midrst pulse", change_pulse_b, 0);
        reset  = 1'b0;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("late location", location_b, 0);
        checkOutput("late valid", location_valid_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lcd_display_location_poller.md
LCD_DISPLAY_LOCATION_POLLER -- requirements
Module: lcd_display_location_poller

Interface
REQ-001 SHALL have parameter POLL_INTERVAL, default 50000, meaning clk cycles from the end of one poll to the start of the next (minimum 1).
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning cycles from accepted read to valid readdata (1..7).
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum waitrequest-high cycles before abort (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  polling enable, level.
REQ-007 SHALL have port avm_address  output  2  slave word address, constant 0.
REQ-008 SHALL have port avm_read  output  1  Avalon-MM read request.
REQ-009 SHALL have port avm_waitrequest  input  1  slave stall.
REQ-010 SHALL have port avm_readdata  input  32  slave read data; only bit 0 used.
REQ-011 SHALL have port location  output  1  last captured location bit.
REQ-012 SHALL have port location_valid  output  1  high once the first poll has completed.
REQ-013 SHALL have port change_pulse  output  1  one-cycle pulse on a location change.
REQ-014 SHALL have port change_count  output  16  number of location changes, wrapping.
REQ-015 SHALL have port timeout_err  output  1  sticky timeout flag.

Function
REQ-016 SHALL implement the FSM IDLE -> REQ -> LAT -> CAP -> IDLE.
REQ-017 IDLE SHALL count up an interval counter while enable=1, hold it while enable=0, and enter REQ when the count reaches POLL_INTERVAL-1 (first poll occurs POLL_INTERVAL cycles after reset release with enable held high).
REQ-018 REQ SHALL drive avm_read=1 and avm_address=0; the read is accepted in the cycle where avm_waitrequest=0, and the FSM then enters LAT.
REQ-019 avm_read SHALL be 0 in every state other than REQ and SHALL stay high continuously while in REQ.
REQ-020 In REQ, if avm_waitrequest has been high for TIMEOUT consecutive cycles, the FSM SHALL drop avm_read, set timeout_err=1, return to IDLE with the interval counter cleared, and leave location unchanged.
REQ-021 LAT SHALL wait READ_LATENCY-1 cycles (zero for READ_LATENCY=1) before CAP, so CAP samples avm_readdata exactly READ_LATENCY cycles after acceptance.
REQ-022 In CAP, the block SHALL register avm_readdata[0] into location and set location_valid=1.
REQ-023 In CAP, if location_valid was already 1 and the new bit differs from location, the block SHALL assert change_pulse for one cycle (the cycle after CAP, aligned with the updated location) and increment change_count.
REQ-024 The first capture after reset SHALL NOT generate change_pulse or increment change_count.
REQ-025 change_count SHALL wrap from 16'hFFFF to 16'h0000 without any flag.
REQ-026 Deasserting enable SHALL only stall IDLE; a read already in REQ/LAT/CAP SHALL complete normally.
REQ-027 timeout_err SHALL clear only on reset; later successful polls SHALL NOT clear it.
REQ-028 avm_readdata bits 31:1 SHALL be ignored.

Reset
REQ-029 While reset=1 on a clock edge: state=IDLE, interval counter=0, timeout counter=0, avm_read=0, avm_address=0, location=0, location_valid=0, change_pulse=0, change_count=0, timeout_err=0.
REQ-030 Reset asserted mid-transaction (REQ or LAT) SHALL abort it with avm_read low on the next cycle, and the late readdata SHALL be discarded.

Verification
REQ-031 POLL_INTERVAL=4, enable=1, slave with waitrequest=0 and latency 1, in_port=1 -> avm_read high for 1 cycle at cycle 4 after reset release; location=1 and location_valid=1 two cycles later; change_pulse stays 0 and change_count=0.
REQ-032 Toggle slave bit 1->0->1 across three polls -> exactly two change_pulse pulses, change_count=2, location=1.
REQ-033 Slave holds waitrequest high for 3 cycles (TIMEOUT=15) -> avm_read held high for 4 cycles, then data captured; timeout_err=0.
REQ-034 Slave holds waitrequest permanently high, TIMEOUT=5 -> avm_read drops after 5 cycles, timeout_err=1 sticky, location unchanged; next poll proceeds after POLL_INTERVAL.
REQ-035 Preload 65535 changes (or force the counter to 16'hFFFF) and apply one further change -> change_count=0 with change_pulse asserted.
REQ-036 Assert reset during LAT with READ_LATENCY=3 -> all outputs at reset values next cycle; no capture occurs from the in-flight read.
